axi_mem_responder: RTL and testbench
====================================

# axi_mem_responder

AXI3 responder (slave) backed by a behavioural 64-bit-wide memory, acting as the DDR end of the frame-delay datapath. It accepts the write bursts issued by the frame sink and serves the read bursts issued by the frame source, so the whole delayer can be simulated without a PS/DDR model. It has independent read and write channels, each with one outstanding burst, INCR/FIXED bursts of 1–16 beats, and 8-byte beats.

## Interface
- BASE, 32'h20000000, byte address of memory word 0
- AW, 21, word-address width; memory holds 2^AW 64-bit words (16 MiB default, covers two 1920x1080x24 frames)
- clk_i  in  1  sole clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- s_axi_awvalid/awready  in/out  1/1  write-address handshake
- s_axi_awaddr/awlen/awburst/awid  in  32/4/2/6  write-address fields; awsize/awlock/awcache/awprot/awqos accepted and ignored
- s_axi_wvalid/wready/wlast  in/out/in  1/1/1  write-data handshake
- s_axi_wdata/wstrb/wid  in  64/8/6  write data, byte strobes; wid ignored
- s_axi_bvalid/bready  out/in  1/1  write-response handshake
- s_axi_bresp/bid  out  2/6  response code, echoed awid
- s_axi_arvalid/arready  in/out  1/1  read-address handshake
- s_axi_araddr/arlen/arburst/arid  in  32/4/2/6  read-address fields; other AR attributes ignored
- s_axi_rvalid/rready/rlast  out/in/out  1/1/1  read-data handshake
- s_axi_rdata/rresp/rid  out  64/2/6  read data, per-beat response, echoed arid

## Operation
- Address map: word index = (addr - BASE) >> 3, 32-bit unsigned subtraction; addr[2:0] ignored. Beat in range iff index < 2^AW.
- Burst address: INCR (01) and WRAP (10) increment index by 1 per beat; FIXED (00) holds it. Burst length = len+1.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1, wready=0. AW handshake latches index, len, burst, id -> W_DATA.
  - W_DATA: awready=0, wready=1. Each W handshake writes bytes with wstrb[i]=1 to mem[index] if in range, else drops the beat and sets an error flag. Beat with wlast=1 (or beat count reaching len+1, whichever first) -> W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if any beat out of range else 2'b00. B handshake -> W_IDLE, error flag cleared.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1, rvalid=0. AR handshake latches fields, loads rdata register with beat 0 -> R_DATA.
  - R_DATA: arready=0, rvalid=1, rid=latched id, rlast=1 on beat len. rdata/rresp hold while rready=0. Handshake on non-last beat loads next beat; on last beat -> R_IDLE.
  - Out-of-range beat: rdata=0, rresp=2'b10; else rresp=2'b00.
- Channels fully independent; both may be active the same cycle.
- Memory contents not reset; uninitialised words read as X in simulation.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=0, bid=0, rdata=0, rresp=0, rid=0. awready/arready rise in first cycle after rst_ni deasserts.
- AW handshake at cycle t -> wready=1 at t+1. W before AW is not accepted (wready=0 in W_IDLE).
- Last W handshake at t -> bvalid=1 at t+1; B handshake at t -> awready=1 at t+1. Minimum one-beat write turnaround: 3 cycles.
- AR handshake at t -> first rvalid at t+1. With rready held high, one beat per cycle; len+1 beats on cycles t+1..t+1+len. Last R handshake at t -> arready=1 at t+1.
- Read/write same word same cycle: read register loads pre-write (old) data.
- rst_ni low mid-burst: all valids/readys drop asynchronously, both FSMs to IDLE, partial burst abandoned, already-written words persist.

## Test plan
- Reset: hold rst_ni=0 with all inputs toggling -> every output 0; release -> awready=arready=1 next cycle, all valids 0.
- Write 4 beats INCR at 0x20000000 (awlen=3, wstrb=8'hFF, data 0x11..,0x22..,0x33..,0x44..), bready=1 -> bvalid 1 cycle after 4th beat, bresp=0, bid=awid; read same address arlen=3 -> identical 4 words, rlast on 4th, rid=arid.
- Strobes: write 0xFFFFFFFFFFFFFFFF then 0x0 with wstrb=8'h0F to same word -> readback 0xFFFFFFFF00000000.
- Read backpressure: 16-beat read with rready toggling 1,0,0,1… -> rdata/rresp/rlast stable during stalls, exactly 16 handshakes, arready low until after last.
- Out of range: 2-beat INCR write at BASE+(2^AW-1)*8 -> first beat stored, second dropped, bresp=2'b10; matching read -> beat 0 data with rresp=0, beat 1 rdata=0 with rresp=2'b10.
- Concurrency and reset: read and write bursts overlapping in time to different words -> both complete correctly; assert rst_ni=0 at beat 2 of an 8-beat write -> wready drops immediately, after release awready=1 and beats 0–1 readable.

Source files
------------

// File: rtl/axi_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_mem_responder
//
// AXI3 responder backed by a behavioural 64-bit-wide memory. It stands in for
// the DDR end of the frame-delay datapath: it absorbs the write bursts of the
// frame sink and serves the read bursts of the frame source.
//
// The read and write channels are independent. Each accepts one burst at a
// time (INCR/WRAP/FIXED, 1-16 beats of 8 bytes). WRAP is treated as INCR.
// Beats whose word index falls outside the memory are dropped on write and
// return zero data on read. Either case is reported with SLVERR.
//
// Parameters
//   BASE  byte address of memory word 0
//   AW    word-address width, memory holds 2^AW 64-bit words (AW < 29)
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   s_axi_aw*                      write address (size/lock/cache/prot/qos ignored)
//   s_axi_w*                       write data with byte strobes (wid ignored)
//   s_axi_b*                       write response, bid echoes awid
//   s_axi_ar*                      read address (size/lock/cache/prot/qos ignored)
//   s_axi_r*                       read data, per-beat rresp, rid echoes arid
// ---------------------------------------------------------------------------
module axi_mem_responder #(
    parameter logic [31:0] BASE = 32'h2000_0000,
    parameter int unsigned AW   = 21
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    // write address channel
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [3:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic [1:0]  s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awqos,
    input  logic [5:0]  s_axi_awid,

    // write data channel
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic        s_axi_wlast,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic [5:0]  s_axi_wid,

    // write response channel
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    output logic [5:0]  s_axi_bid,

    // read address channel
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [3:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic [1:0]  s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arqos,
    input  logic [5:0]  s_axi_arid,

    // read data channel
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        s_axi_rlast,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic [5:0]  s_axi_rid
);

    // Word index width: a 32-bit byte offset shifted right by 3.
    localparam int unsigned IDX_W = 29;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [63:0] mem [DEPTH];

    // Low for the whole reset and for the first clock edge after it, so that
    // awready/arready stay 0 while rst_ni is asserted.
    logic active_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before the clock edge.
        if (!rst_ni) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Write channel
    // -----------------------------------------------------------------------
    w_state_e         w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q;
    logic [IDX_W-1:0] w_idx_next;
    logic [3:0]       w_len_q;
    logic [3:0]       w_cnt_q;
    logic [1:0]       w_burst_q;
    logic [5:0]       w_id_q;
    logic             w_err_q;
    logic [31:0]      aw_off;
    logic             aw_fire, w_fire, b_fire;
    logic             w_last_beat;
    logic             w_in_range;

    assign aw_off      = s_axi_awaddr - BASE;
    assign aw_fire     = s_axi_awvalid && s_axi_awready;
    assign w_fire      = s_axi_wvalid && s_axi_wready;
    assign b_fire      = s_axi_bvalid && s_axi_bready;
    // The burst ends on wlast or when len+1 beats have arrived, whichever
    // comes first; a missing wlast cannot wedge the channel.
    assign w_last_beat = s_axi_wlast || (w_cnt_q == w_len_q);
    assign w_in_range  = (w_idx_q >> AW) == '0;
    assign w_idx_next  = (w_burst_q == BURST_FIXED) ? w_idx_q : w_idx_q + IDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        w_state_d     = w_state_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                s_axi_awready = active_q;
                if (active_q && s_axi_awvalid) begin
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_last_beat) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_err_q   <= 1'b0;
        end else begin
            if (aw_fire) begin
                w_idx_q   <= aw_off[31:3];
                w_len_q   <= s_axi_awlen;
                w_burst_q <= s_axi_awburst;
                w_id_q    <= s_axi_awid;
                w_cnt_q   <= '0;
            end
            if (w_fire) begin
                w_cnt_q <= w_cnt_q + 4'd1;
                w_idx_q <= w_idx_next;
                if (!w_in_range) begin
                    w_err_q <= 1'b1;
                end
            end
            if (b_fire) begin
                w_err_q <= 1'b0;
            end
        end
    end

    assign s_axi_bresp = (w_state_q == W_RESP && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_bid   = w_id_q;

    // NOTE: the memory array has no reset; clearing millions of words is not
    // something real DRAM does, and only control state must be reset.
    always_ff @(posedge clk_i) begin
        if (w_fire && w_in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx_q[AW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    r_state_e         r_state_q, r_state_d;
    logic [IDX_W-1:0] r_idx_q;
    logic [IDX_W-1:0] r_idx_next;
    logic [IDX_W-1:0] r_load_idx;
    logic [3:0]       r_len_q;
    logic [3:0]       r_beat_q;
    logic [1:0]       r_burst_q;
    logic [5:0]       r_id_q;
    logic [63:0]      r_data_q;
    logic [1:0]       r_resp_q;
    logic [31:0]      ar_off;
    logic             ar_fire, r_fire;
    logic             r_last;
    logic             r_load;
    logic             r_load_in_range;

    assign ar_off     = s_axi_araddr - BASE;
    assign ar_fire    = s_axi_arvalid && s_axi_arready;
    assign r_fire     = s_axi_rvalid && s_axi_rready;
    assign r_last     = (r_beat_q == r_len_q);
    assign r_idx_next = (r_burst_q == BURST_FIXED) ? r_idx_q : r_idx_q + IDX_W'(1);

    // The data register is refilled on the address handshake (beat 0) and on
    // every accepted non-last beat (the following beat), so rdata always
    // holds the beat currently offered and is stable while rready is low.
    assign r_load          = ar_fire || (r_fire && !r_last);
    assign r_load_idx      = ar_fire ? ar_off[31:3] : r_idx_next;
    assign r_load_in_range = (r_load_idx >> AW) == '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d     = r_state_q;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                s_axi_arready = active_q;
                if (active_q && s_axi_arvalid) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && r_last) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // A write to the same word in the same cycle lands after this read, so
    // the register captures the old contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            if (ar_fire) begin
                r_len_q   <= s_axi_arlen;
                r_burst_q <= s_axi_arburst;
                r_id_q    <= s_axi_arid;
                r_beat_q  <= '0;
            end else if (r_fire && !r_last) begin
                r_beat_q <= r_beat_q + 4'd1;
            end
            if (r_load) begin
                r_idx_q  <= r_load_idx;
                r_data_q <= r_load_in_range ? mem[r_load_idx[AW-1:0]] : '0;
                r_resp_q <= r_load_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign s_axi_rdata = r_data_q;
    assign s_axi_rresp = r_resp_q;
    assign s_axi_rid   = r_id_q;
    assign s_axi_rlast = (r_state_q == R_DATA) && r_last;

    // Attributes this memory model does not act on, plus the byte-offset
    // bits below the 8-byte beat.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_awqos, s_axi_wid, s_axi_arsize, s_axi_arlock,
                             s_axi_arcache, s_axi_arprot, s_axi_arqos,
                             aw_off[2:0], ar_off[2:0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_responder
//
// Drives randomized AXI3 bursts into axi_mem_responder and compares every
// response against a word-array model of the memory. The model applies the
// address map and strobe rules directly, one beat at a time.
// A reduced AW keeps the memory small enough to fill completely.
// ---------------------------------------------------------------------------
module tb_axi_mem_responder;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          AW    = 12;
    localparam int          DEPTH = 1 << AW;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;

    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [3:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic [1:0]  s_axi_awlock;
    logic [3:0]  s_axi_awcache;
    logic [2:0]  s_axi_awprot;
    logic [3:0]  s_axi_awqos;
    logic [5:0]  s_axi_awid;
    logic        s_axi_wvalid, s_axi_wready, s_axi_wlast;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic [5:0]  s_axi_wid;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic [5:0]  s_axi_bid;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [3:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic [1:0]  s_axi_arlock;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic [3:0]  s_axi_arqos;
    logic [5:0]  s_axi_arid;
    logic        s_axi_rvalid, s_axi_rready, s_axi_rlast;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic [5:0]  s_axi_rid;

    int checks   = 0;
    int failures = 0;

    logic [63:0] model   [DEPTH];
    logic [63:0] wr_data [16];
    logic [7:0]  wr_strb [16];

    always #5 clk_i = ~clk_i;

    axi_mem_responder #(.BASE(BASE), .AW(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
        .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos), .s_axi_awid(s_axi_awid),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wlast(s_axi_wlast),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wid(s_axi_wid),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
        .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos), .s_axi_arid(s_axi_arid),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rlast(s_axi_rlast),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid)
    );

    // ------------------------------------------------------------------ model
    // Word index of a beat: (addr - BASE) / 8, advancing by one per beat
    // unless the burst is FIXED.
    function automatic logic [31:0] beat_index(input logic [31:0] addr, input logic [1:0] burst,
                                               input int beat);
        logic [31:0] w0;
        w0 = (addr - BASE) >> 3;
        return (burst == 2'b00) ? w0 : w0 + 32'(beat);
    endfunction

    // Applies wr_data/wr_strb to the model and returns the expected bresp.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                               input logic [1:0] burst);
        logic [31:0] idx;
        bit          err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            idx = beat_index(addr, burst, i);
            if (idx < DEPTH) begin
                for (int b = 0; b < 8; b++)
                    if (wr_strb[i][b]) model[idx][8*b +: 8] = wr_data[i][8*b +: 8];
            end else begin
                err = 1'b1;
            end
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    // ------------------------------------------------------------ utilities
    task automatic timeout_fail(input string what);
        checks++;
        failures++;
        $display("FAIL %s: handshake did not occur within the cycle budget", what);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic idle_inputs();
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0;
        s_axi_awburst = 0; s_axi_awlock = 0; s_axi_awcache = 0; s_axi_awprot = 0;
        s_axi_awqos = 0; s_axi_awid = 0;
        s_axi_wvalid = 0; s_axi_wlast = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wid = 0;
        s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0;
        s_axi_arburst = 0; s_axi_arlock = 0; s_axi_arcache = 0; s_axi_arprot = 0;
        s_axi_arqos = 0; s_axi_arid = 0;
        s_axi_rready = 0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Full write burst using wr_data/wr_strb; all driving on the falling edge.
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [5:0] id, input bit gaps, input bit chk_timing,
                             input string tag);
        logic [1:0] exp_resp;
        int         t;
        exp_resp = model_write(addr, len, burst);
        @(negedge clk_i);
        s_axi_awvalid = 1; s_axi_awaddr = addr; s_axi_awlen = 4'(len);
        s_axi_awburst = burst; s_axi_awid = id;
        s_axi_awsize = 3'($urandom); s_axi_awlock = 2'($urandom);
        s_axi_awcache = 4'($urandom); s_axi_awprot = 3'($urandom); s_axi_awqos = 4'($urandom);
        t = 0;
        while (!s_axi_awready && t < 100) begin @(negedge clk_i); t++; end
        if (!s_axi_awready) begin timeout_fail({tag, "_aw"}); return; end
        @(negedge clk_i);
        s_axi_awvalid = 0;
        if (chk_timing) check_bit({tag, "_wready_after_aw"}, s_axi_wready, 1'b1);
        for (int i = 0; i <= len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
            s_axi_wvalid = 1; s_axi_wdata = wr_data[i]; s_axi_wstrb = wr_strb[i];
            s_axi_wlast = (i == len); s_axi_wid = 6'($urandom);
            t = 0;
            while (!s_axi_wready && t < 100) begin @(negedge clk_i); t++; end
            if (!s_axi_wready) begin timeout_fail({tag, "_w"}); return; end
            @(negedge clk_i);
            s_axi_wvalid = 0; s_axi_wlast = 0;
        end
        if (chk_timing) check_bit({tag, "_bvalid_after_last_w"}, s_axi_bvalid, 1'b1);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
        s_axi_bready = 1;
        t = 0;
        while (!s_axi_bvalid && t < 100) begin @(negedge clk_i); t++; end
        if (!s_axi_bvalid) begin timeout_fail({tag, "_b"}); return; end
        checks++;
        if (s_axi_bresp !== exp_resp) begin
            failures++;
            $display("FAIL %s_bresp: got %b expected %b", tag, s_axi_bresp, exp_resp);
        end
        checks++;
        if (s_axi_bid !== id) begin
            failures++;
            $display("FAIL %s_bid: got %h expected %h", tag, s_axi_bid, id);
        end
        @(negedge clk_i);
        s_axi_bready = 0;
        if (chk_timing) begin
            check_bit({tag, "_awready_after_b"}, s_axi_awready, 1'b1);
            check_bit({tag, "_bvalid_dropped"}, s_axi_bvalid, 1'b0);
        end
    endtask

    // Full read burst. mode 0: rready always 1; mode 1: 1,0,0 repeating;
    // otherwise random rready. Beats are compared against the model.
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [5:0] id, input int mode, input bit chk_timing,
                            input string tag);
        int          t, beats, cyc;
        bit          stalled;
        logic [66:0] held;
        logic [31:0] idx;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        @(negedge clk_i);
        s_axi_arvalid = 1; s_axi_araddr = addr; s_axi_arlen = 4'(len);
        s_axi_arburst = burst; s_axi_arid = id;
        s_axi_arsize = 3'($urandom); s_axi_arlock = 2'($urandom);
        s_axi_arcache = 4'($urandom); s_axi_arprot = 3'($urandom); s_axi_arqos = 4'($urandom);
        t = 0;
        while (!s_axi_arready && t < 100) begin @(negedge clk_i); t++; end
        if (!s_axi_arready) begin timeout_fail({tag, "_ar"}); return; end
        @(negedge clk_i);
        s_axi_arvalid = 0;
        if (chk_timing) check_bit({tag, "_rvalid_after_ar"}, s_axi_rvalid, 1'b1);
        beats = 0; cyc = 0; stalled = 0; held = '0;
        while (beats <= len && cyc < 300) begin
            case (mode)
                0:       s_axi_rready = 1'b1;
                1:       s_axi_rready = (cyc % 3 == 0);
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                checks++;
                if ({s_axi_rdata, s_axi_rresp, s_axi_rlast} !== held) begin
                    failures++;
                    $display("FAIL %s_stall_hold: got %h expected %h", tag,
                             {s_axi_rdata, s_axi_rresp, s_axi_rlast}, held);
                end
            end
            stalled = 0;
            if (s_axi_rvalid && s_axi_rready) begin
                idx = beat_index(addr, burst, beats);
                if (idx < DEPTH) begin exp_data = model[idx]; exp_resp = 2'b00; end
                else             begin exp_data = '0;         exp_resp = 2'b10; end
                checks++;
                if (s_axi_rdata !== exp_data) begin
                    failures++;
                    $display("FAIL %s_rdata beat %0d: got %h expected %h", tag, beats,
                             s_axi_rdata, exp_data);
                end
                checks++;
                if (s_axi_rresp !== exp_resp) begin
                    failures++;
                    $display("FAIL %s_rresp beat %0d: got %b expected %b", tag, beats,
                             s_axi_rresp, exp_resp);
                end
                check_bit({tag, "_rlast"}, s_axi_rlast, 1'(beats == len));
                checks++;
                if (s_axi_rid !== id) begin
                    failures++;
                    $display("FAIL %s_rid: got %h expected %h", tag, s_axi_rid, id);
                end
                beats++;
            end else if (s_axi_rvalid) begin
                stalled = 1;
                held    = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
            end
            if (chk_timing) check_bit({tag, "_arready_busy"}, s_axi_arready, 1'b0);
            @(negedge clk_i);
            cyc++;
        end
        s_axi_rready = 0;
        if (beats <= len) begin timeout_fail({tag, "_r"}); return; end
        if (chk_timing) begin
            check_bit({tag, "_no_extra_beat"}, s_axi_rvalid, 1'b0);
            check_bit({tag, "_arready_after_last"}, s_axi_arready, 1'b1);
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_ni = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            s_axi_awvalid = 1'($urandom); s_axi_wvalid = 1'($urandom);
            s_axi_bready = 1'($urandom); s_axi_arvalid = 1'($urandom);
            s_axi_rready = 1'($urandom); s_axi_wlast = 1'($urandom);
            s_axi_awaddr = $urandom; s_axi_araddr = $urandom;
            s_axi_wdata = {$urandom, $urandom}; s_axi_wstrb = 8'($urandom);
            #1;
            checks++;
            if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_bid,
                 s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rdata, s_axi_rresp,
                 s_axi_rid} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got nonzero outputs, expected all 0", c);
            end
        end
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        check_bit("reset_awready_rise", s_axi_awready, 1'b1);
        check_bit("reset_arready_rise", s_axi_arready, 1'b1);
        check_bit("reset_wready_low", s_axi_wready, 1'b0);
        check_bit("reset_bvalid_low", s_axi_bvalid, 1'b0);
        check_bit("reset_rvalid_low", s_axi_rvalid, 1'b0);
    endtask

    // Gives every word a known value so later reads never hit uninitialised data.
    task automatic test_fill();
        for (int blk = 0; blk < DEPTH / 16; blk++) begin
            for (int i = 0; i < 16; i++) begin
                wr_data[i] = {$urandom, $urandom};
                wr_strb[i] = 8'hFF;
            end
            axi_write(BASE + 32'(blk * 128), 15, 2'b01, 6'($urandom), 0, 0, "fill");
        end
    endtask

    task automatic test_basic();
        wr_data[0] = 64'h1111_1111_1111_1111; wr_data[1] = 64'h2222_2222_2222_2222;
        wr_data[2] = 64'h3333_3333_3333_3333; wr_data[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) wr_strb[i] = 8'hFF;
        axi_write(BASE, 3, 2'b01, 6'h15, 0, 1, "basic_wr");
        axi_read(BASE, 3, 2'b01, 6'h2A, 0, 1, "basic_rd");
    endtask

    task automatic test_strobes();
        wr_data[0] = '1; wr_strb[0] = 8'hFF;
        axi_write(BASE + 32'h28, 0, 2'b01, 6'h01, 0, 1, "strb_wr1");
        wr_data[0] = '0; wr_strb[0] = 8'h0F;
        axi_write(BASE + 32'h28, 0, 2'b01, 6'h02, 0, 1, "strb_wr2");
        axi_read(BASE + 32'h28, 0, 2'b01, 6'h03, 0, 1, "strb_rd");
    endtask

    task automatic test_read_backpressure();
        for (int i = 0; i < 16; i++) begin
            wr_data[i] = {$urandom, $urandom};
            wr_strb[i] = 8'hFF;
        end
        axi_write(BASE + 32'h800, 15, 2'b01, 6'h07, 0, 0, "bp_wr");
        axi_read(BASE + 32'h800, 15, 2'b01, 6'h31, 1, 1, "bp_rd");
    endtask

    task automatic test_out_of_range();
        wr_data[0] = {$urandom, $urandom}; wr_data[1] = {$urandom, $urandom};
        wr_strb[0] = 8'hFF;                wr_strb[1] = 8'hFF;
        axi_write(BASE + 32'((DEPTH - 1) * 8), 1, 2'b01, 6'h3F, 0, 1, "oor_wr");
        axi_read(BASE + 32'((DEPTH - 1) * 8), 1, 2'b01, 6'h3E, 0, 1, "oor_rd");
        // The dropped beat must not have wrapped onto word 0.
        axi_read(BASE, 0, 2'b01, 6'h00, 0, 0, "oor_word0");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [1:0]  burst;
        int          len;
        for (int n = 0; n < 24; n++) begin
            len   = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0)
                addr = BASE - 32'h1000 + 32'($urandom_range(0, 63) << 3);
            else
                addr = BASE + 32'($urandom_range(0, DEPTH + 4) << 3) + 32'($urandom_range(0, 7));
            for (int i = 0; i < 16; i++) begin
                wr_data[i] = {$urandom, $urandom};
                wr_strb[i] = 8'($urandom);
            end
            axi_write(addr, len, burst, 6'($urandom), 1, 0, "rand_wr");
            axi_read(addr, len, burst, 6'($urandom), 2, 0, "rand_rd");
        end
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 8; i++) begin
            wr_data[i] = {$urandom, $urandom};
            wr_strb[i] = 8'($urandom);
        end
        fork
            axi_write(BASE + 32'(1000 * 8), 7, 2'b01, 6'h11, 1, 0, "conc_wr");
            axi_read(BASE + 32'(2000 * 8), 7, 2'b01, 6'h22, 2, 0, "conc_rd");
        join
        axi_read(BASE + 32'(1000 * 8), 7, 2'b01, 6'h23, 0, 0, "conc_wr_check");
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] addr;
        int          t;
        addr = BASE + 32'(300 * 8);
        for (int i = 0; i < 8; i++) begin
            wr_data[i] = {$urandom, $urandom};
            wr_strb[i] = 8'hFF;
        end
        @(negedge clk_i);
        s_axi_awvalid = 1; s_axi_awaddr = addr; s_axi_awlen = 4'd7;
        s_axi_awburst = 2'b01; s_axi_awid = 6'h09;
        t = 0;
        while (!s_axi_awready && t < 100) begin @(negedge clk_i); t++; end
        if (!s_axi_awready) begin timeout_fail("rstmid_aw"); return; end
        @(negedge clk_i);
        s_axi_awvalid = 0;
        for (int i = 0; i < 3; i++) begin
            s_axi_wvalid = 1; s_axi_wdata = wr_data[i]; s_axi_wstrb = 8'hFF; s_axi_wlast = 0;
            t = 0;
            while (!s_axi_wready && t < 100) begin @(negedge clk_i); t++; end
            if (!s_axi_wready) begin timeout_fail("rstmid_w"); return; end
            if (i < 2) @(negedge clk_i);
        end
        // Beat 2 is on the bus and about to be accepted: pull reset now.
        rst_ni = 0;
        #1;
        check_bit("rstmid_wready_drop", s_axi_wready, 1'b0);
        check_bit("rstmid_awready_low", s_axi_awready, 1'b0);
        check_bit("rstmid_bvalid_low", s_axi_bvalid, 1'b0);
        for (int i = 0; i < 2; i++) model[300 + i] = wr_data[i];
        repeat (2) @(negedge clk_i);
        idle_inputs();
        rst_ni = 1;
        @(negedge clk_i);
        check_bit("rstmid_awready_after", s_axi_awready, 1'b1);
        check_bit("rstmid_arready_after", s_axi_arready, 1'b1);
        axi_read(addr, 7, 2'b01, 6'h0A, 0, 0, "rstmid_rd");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_basic();
        test_strobes();
        test_read_backpressure();
        test_out_of_range();
        test_random();
        test_concurrent();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        timeout_fail("global_watchdog");
    end

endmodule
